// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite burst master: one command per handshake, SINGLE/INCR/INCRx/WRAPx with pipelined phases.
// Optional AHB_MST_ERR_ABORT_EN: an ERROR response cancels the remaining beats of the burst.
module ahb_lite_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HBURST,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP
);

  localparam int CNT_W    = (LEN_W > 5) ? LEN_W : 5;
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] haddr_q,    haddr_d;
  logic [1:0]        htrans_q,   htrans_d;
  logic [2:0]        hburst_q,   hburst_d;
  logic [2:0]        hsize_q,    hsize_d;
  logic              hwrite_q,   hwrite_d;
  logic [DATA_W-1:0] hwdata_q,   hwdata_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              dph_q,      dph_d;
  logic              err_acc_q,  err_acc_d;

  logic [2:0]        size_c;
  logic [CNT_W-1:0]  first_cnt;
  logic [ADDR_W-1:0] step, inc_addr, wrap_addr, next_addr;
  logic [7:0]        wrap_beats, wrap_mask;
  logic              is_wrap, kb_cross, addr_done, resp_hit;

  // Gated by reset so every output reads 0 while HRESETn is low.
  assign cmd_ready = (state_q == ST_IDLE) && HRESETn;
  assign wr_pop    = HREADY && hwrite_q && (htrans_q != HT_IDLE);
  assign addr_done = (htrans_q != HT_IDLE) && HREADY;
  assign resp_hit  = dph_q && HRESP;

  always_comb begin
    size_c = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
    case (cmd_burst)
      3'b000:         first_cnt = '0;
      3'b001:         first_cnt = CNT_W'(cmd_len);
      3'b010, 3'b011: first_cnt = CNT_W'(3);
      3'b100, 3'b101: first_cnt = CNT_W'(7);
      default:        first_cnt = CNT_W'(15);
    endcase
  end

  // Wrapping keeps the upper address bits and rolls only the low beats<<size window.
  always_comb begin
    step     = ADDR_W'(1) << hsize_q;
    inc_addr = haddr_q + step;
    is_wrap  = (hburst_q != HB_SINGLE) && !hburst_q[0];
    case (hburst_q[2:1])
      2'b01:   wrap_beats = 8'd4;
      2'b10:   wrap_beats = 8'd8;
      default: wrap_beats = 8'd16;
    endcase
    wrap_mask = (wrap_beats << hsize_q) - 8'd1;
    wrap_addr = (haddr_q & ~ADDR_W'(wrap_mask)) | (inc_addr & ADDR_W'(wrap_mask));
    next_addr = is_wrap ? wrap_addr : inc_addr;
    kb_cross  = !is_wrap && (next_addr[9:0] == '0);
  end

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hburst_d   = hburst_q;
    hsize_d    = hsize_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    dph_d      = HREADY ? (htrans_q != HT_IDLE) : dph_q;
    err_acc_d  = err_acc_q | resp_hit;

    if (wr_pop) hwdata_d = wr_data;

    if (dph_q && HREADY && !hwrite_q) begin
      rd_data_d = HRDATA;
`ifdef AHB_MST_ERR_ABORT_EN
      rd_valid_d = !HRESP;
`else
      rd_valid_d = 1'b1;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = ST_ADDR;
          haddr_d   = cmd_addr;
          htrans_d  = HT_NONSEQ;
          hburst_d  = cmd_burst;
          hsize_d   = size_c;
          hwrite_d  = cmd_write;
          cnt_d     = first_cnt;
          err_acc_d = 1'b0;
        end
      end
      ST_ADDR: begin
        if (addr_done) begin
          if (cnt_q == '0) begin
            htrans_d = HT_IDLE;
            state_d  = ST_LAST;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            haddr_d = next_addr;
            if (kb_cross) begin
              htrans_d = HT_NONSEQ;
              hburst_d = HB_INCR;
            end else begin
              htrans_d = HT_SEQ;
            end
          end
        end
      end
      ST_LAST: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = err_acc_q | resp_hit;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AHB_MST_ERR_ABORT_EN
    // First ERROR cycle: drop the pending address phase and finish with the errored data phase.
    if ((state_q != ST_IDLE) && resp_hit && !HREADY) begin
      htrans_d = HT_IDLE;
      state_d  = ST_LAST;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      htrans_q   <= HT_IDLE;
      hburst_q   <= '0;
      hsize_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      dph_q      <= 1'b0;
      err_acc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hburst_q   <= hburst_d;
      hsize_q    <= hsize_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      dph_q      <= dph_d;
      err_acc_q  <= err_acc_d;
    end
  end

  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HBURST   = hburst_q;
  assign HSIZE    = hsize_q;
  assign HWRITE   = hwrite_q;
  assign HWDATA   = hwdata_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Scoreboard bench for ahb_lite_burst_master: reference beat lists from burst arithmetic, AHB slave model.
module tb_ahb_lite_burst_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 5;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic cmd_valid, cmd_ready, cmd_write, wr_pop, rd_valid, done, err;
  logic [AW-1:0] cmd_addr, HADDR;
  logic [2:0] cmd_burst, cmd_size, HBURST, HSIZE;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic HWRITE, HREADY, HRESP;

  ahb_lite_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=no-event", name, act);
  endtask

  // Scoreboard queues
  logic [40:0] aq[$];
  logic [31:0] wq[$], rq[$], srcq[$];
  logic        eq[$];

  // Slave model state
  int err_beat = 99, wait_beat = 99, wait_n = 0, wait_left = 0, err_phase = 0;
  int s_started = 0, s_beat = 0;
  bit rand_waits = 0, s_dph = 0, s_dwrite = 0, new_ph;
  logic [31:0] s_daddr = '0, rseed = '0;
  bit cap_hready = 0, cap_addr_done = 0, cap_write = 0, cap_pop = 0;
  logic [31:0] cap_addr = '0;

  // Monitor state
  bit rv_pend = 0, done_pend = 0, prev_pend = 0;
  logic [40:0] prev_ctrl = '0;
  int dcount = 0, ndata = -1, done_cnt = 0;
  int unsigned cyc = 0, hs_cyc = 0, done_cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin : monitor
    logic [40:0] ctrl;
    bit dnow;
    ctrl = {HADDR, HTRANS, HBURST, HSIZE, HWRITE};
    if (!HRESETn) begin
      prev_pend = 0; rv_pend = 0; done_pend = 0;
      cap_hready = 0; cap_addr_done = 0; cap_pop = 0;
    end else begin
      if (prev_pend) check("addr_hold", ctrl, prev_ctrl);
      if (HTRANS != 2'b00 && HREADY) begin
        if (aq.size() == 0) fail_now("addr_unexpected", ctrl);
        else check("addr_phase", ctrl, aq.pop_front());
      end
      if (wr_pop && srcq.size() == 0) fail_now("wr_pop_unexpected", HADDR);
      dnow = s_dph && HREADY;
      if (dnow) begin
        if (s_dwrite) begin
          if (wq.size() == 0) fail_now("hwdata_unexpected", HWDATA);
          else check("hwdata", HWDATA, wq.pop_front());
        end
        dcount++;
      end
      if (rd_valid || rv_pend) begin
        check("rd_valid_timing", rd_valid, rv_pend);
        if (rd_valid) begin
          if (rq.size() == 0) fail_now("rd_unexpected", rd_data);
          else check("rd_data", rd_data, rq.pop_front());
        end
      end
`ifdef AHB_MST_ERR_ABORT_EN
      rv_pend = dnow && !s_dwrite && !HRESP;
`else
      rv_pend = dnow && !s_dwrite;
`endif
      if (done || done_pend) begin
        check("done_timing", done, done_pend);
        if (done) begin
          done_cyc = cyc;
          done_cnt++;
          if (eq.size() == 0) fail_now("done_unexpected", err);
          else check("err", err, eq.pop_front());
          check("addr_beats_left", aq.size(), 0);
        end
      end
      done_pend = dnow && (dcount == ndata);
      prev_pend = (HTRANS != 2'b00) && !HREADY && !HRESP;
      prev_ctrl = ctrl;
      cap_hready = HREADY;
      cap_addr_done = (HTRANS != 2'b00) && HREADY;
      cap_addr = HADDR;
      cap_write = HWRITE;
      cap_pop = wr_pop;
    end
  end

  always @(posedge HCLK) begin : slave
    #1;
    if (HRESETn) begin
      if (cap_pop && srcq.size() != 0) void'(srcq.pop_front());
      cap_pop = 0;
      wr_data = (srcq.size() != 0) ? srcq[0] : '0;
      new_ph = 0;
      if (cap_hready) begin
        s_dph = cap_addr_done;
        if (cap_addr_done) begin
          s_daddr = cap_addr; s_dwrite = cap_write;
          s_beat = s_started; s_started++;
          new_ph = 1;
        end
      end
      if (err_phase != 0) begin
        HREADY = 1'b1; HRESP = 1'b1; err_phase = 0;
      end else if (new_ph && s_beat == err_beat) begin
        HREADY = 1'b0; HRESP = 1'b1; err_phase = 1;
      end else begin
        HRESP = 1'b0;
        if (new_ph && s_beat == wait_beat) wait_left = wait_n;
        if (wait_left > 0) begin
          HREADY = 1'b0; wait_left--;
        end else begin
          HREADY = rand_waits ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
      HRDATA = s_daddr ^ rseed;
    end
  end

  function automatic int beats(input logic [2:0] b, input logic [LW-1:0] len);
    case (b)
      3'd0: return 1;
      3'd1: return int'(len) + 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  task automatic wait_done(input int c0);
    int i = 0;
    while (done_cnt == c0 && i < 3000) begin
      @(negedge HCLK);
      i++;
    end
    if (done_cnt == c0) fail_now("done_timeout", i);
    @(negedge HCLK);
    check("wdata_left", wq.size(), 0);
    check("rdata_left", rq.size(), 0);
    srcq.delete();
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] burst,
                       input logic [2:0] size, input logic [LW-1:0] len,
                       input int eb, input int wb, input int wn, input bit rw, input bit wait_end);
    int n, nd, nr, c0, tries;
    logic [2:0] szv;
    logic [31:0] bytes, blk, base, a, w;
    logic [1:0] t;
    logic [2:0] b;
    bit wrap, broken;
    szv = (size > 3'd2) ? 3'd2 : size;
    bytes = 32'd1 << szv;
    n = beats(burst, len);
    wrap = (burst == 3'd2) || (burst == 3'd4) || (burst == 3'd6);
    nd = n; nr = n;
`ifdef AHB_MST_ERR_ABORT_EN
    if (eb < n) begin nd = eb + 1; nr = eb; end
`endif
    @(negedge HCLK);
    c0 = done_cnt;
    rseed = $urandom;
    err_beat = eb; wait_beat = wb; wait_n = wn; rand_waits = rw;
    s_started = 0; ndata = nd; dcount = 0;
    broken = 0;
    blk = 32'(n) * bytes;
    base = addr - (addr % blk);
    for (int k = 0; k < n; k++) begin
      if (wrap) begin
        a = base + ((addr - base + 32'(k) * bytes) % blk);
        t = (k == 0) ? 2'b10 : 2'b11;
        b = burst;
      end else begin
        a = addr + 32'(k) * bytes;
        if (k > 0 && a[9:0] == 10'd0) broken = 1;
        t = (k == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
        b = broken ? 3'b001 : burst;
      end
      if (k < nd) begin
        aq.push_back({a, t, b, szv, wr});
        if (wr) begin
          w = $urandom;
          srcq.push_back(w);
          wq.push_back(w);
        end else if (k < nr) begin
          rq.push_back(a ^ rseed);
        end
      end
    end
    eq.push_back(eb < n);
    wr_data = (srcq.size() != 0) ? srcq[0] : '0;
    cmd_write = wr; cmd_addr = addr; cmd_burst = burst; cmd_size = size; cmd_len = len;
    cmd_valid = 1'b1;
    tries = 0;
    while (!cmd_ready && tries < 50) begin
      @(negedge HCLK);
      tries++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout", tries);
    hs_cyc = cyc;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    if (wait_end) wait_done(c0);
  endtask

  function automatic logic [127:0] outs();
    return {cmd_ready, wr_pop, rd_valid, done, err, HTRANS, HBURST, HSIZE, HWRITE,
            HADDR, HWDATA, rd_data};
  endfunction

  initial begin
    logic [31:0] ad;
    logic [2:0] bu, sz;
    logic [LW-1:0] ln;
    int n, eb;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_burst = '0; cmd_size = '0; cmd_len = '0;
    wr_data = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (3) @(negedge HCLK);
    check("reset_outputs", outs(), '0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("cmd_ready_idle", cmd_ready, 1'b1);

    // INCR4 write, zero wait: done six cycles after the handshake cycle
    issue(1, 32'h100, 3'b011, 3'd2, '0, 99, 99, 0, 0, 1);
    check("incr4_latency", done_cyc - hs_cyc, 6);
    // WRAP8 read with two wait states on beat 3
    issue(0, 32'h34, 3'b100, 3'd2, '0, 99, 3, 2, 0, 1);
    // INCR len 4 across the 1KB boundary
    issue(1, 32'h3F8, 3'b001, 3'd2, 5'd3, 99, 99, 0, 0, 1);
    // INCR4 rolling over the top of the address space
    issue(1, 32'hFFFF_FFF8, 3'b011, 3'd2, '0, 99, 99, 0, 0, 1);
    // SINGLE read with HREADY low three cycles
    issue(0, 32'h40, 3'b000, 3'd2, '0, 99, 0, 3, 0, 1);
    // INCR8 read with two-cycle ERROR on beat 2
    issue(0, 32'h800, 3'b101, 3'd2, '0, 2, 99, 0, 0, 1);
    // Oversized HSIZE clamps to the bus width
    issue(0, 32'h1000, 3'b010, 3'd5, '0, 99, 99, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      bu = 3'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 7));
      ln = LW'($urandom);
      ad = $urandom;
      if ($urandom_range(0, 2) == 0) ad[9:0] = 10'h3C0 | 10'($urandom_range(0, 63));
      ad = ad & ~((32'd1 << ((sz > 3'd2) ? 3'd2 : sz)) - 32'd1);
      n = beats(bu, ln);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : 99;
      issue(1'($urandom), ad, bu, sz, ln, eb, $urandom_range(0, 4), $urandom_range(0, 2),
            1'($urandom), 1);
    end

    // Reset during beat 2 of an INCR16 write
    issue(1, 32'h200, 3'b111, 3'd2, '0, 99, 99, 0, 0, 0);
    for (int i = 0; i < 100 && aq.size() > 14; i++) @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1 check("reset_midburst_outputs", outs(), '0);
    aq.delete(); wq.delete(); rq.delete(); srcq.delete(); eq.delete();
    s_dph = 0; err_phase = 0; wait_left = 0; ndata = -1; dcount = 0;
    wr_data = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      check("reset_no_done", done, 1'b0);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    issue(0, 32'h60, 3'b000, 3'd2, '0, 99, 99, 0, 0, 1);

    repeat (3) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
